// File: rtl/julia_pkg.sv
// Shared types for the julia renderer: worker indices, pixel types
// and the pixel write arbiter state encoding.
package julia_pkg;

  localparam int NUM_WORKERS_DEF = 16;

  typedef logic [31:0] pix_addr_t;
  typedef logic [31:0] pix_color_t;

  typedef logic [$clog2(16)-1:0] worker_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotated priority encoder: first set bit of req scanning from rr_ptr
// upward, wrapping at N. Shared by the arbiter and the dispatcher.
module rr_priority_pick #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  always_comb begin
    int j;
    j       = 0;
    grant   = '0;
    any_req = |req;
    // scan backwards so the lowest rotated position wins last
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) grant = IW'(j);
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter from the julia workers onto the pixel write port.
// Define MC_PIX_CNT_EN to add the pix_count / cnt_clr written-pixel counter.
module pixel_write_arbiter
  import julia_pkg::*;
#(
  parameter int NUM_WORKERS = NUM_WORKERS_DEF,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic [NUM_WORKERS-1:0]             jw_done,
  input  logic [NUM_WORKERS-1:0][DATA_W-1:0] color,
  input  logic [NUM_WORKERS-1:0][ADDR_W-1:0] address,
  input  logic                               wr_done,
  output logic [NUM_WORKERS-1:0]             mc_done,
  output logic [NUM_WORKERS-1:0]             mc_busy,
  output logic [ADDR_W-1:0]                  wr_addr,
  output logic [DATA_W-1:0]                  wr_data,
  output logic                               wr_ready
`ifdef MC_PIX_CNT_EN
  ,
  input  logic                               cnt_clr,
  output logic [31:0]                        pix_count
`endif
);

  localparam int IW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

  arb_state_t state, state_n;

  logic [IW-1:0]          rr_ptr, ptr_n;
  logic [IW-1:0]          grant, grant_n;
  logic [IW-1:0]          pick;
  logic                   any_req;
  logic                   ready_n;
  logic [ADDR_W-1:0]      addr_n;
  logic [DATA_W-1:0]      data_n;
  logic [NUM_WORKERS-1:0] done_n;
  logic [NUM_WORKERS-1:0] busy_n;

  rr_priority_pick #(
    .N  (NUM_WORKERS),
    .IW (IW)
  ) u_pick (
    .req     (jw_done),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  always_comb begin
    state_n = state;
    ptr_n   = rr_ptr;
    grant_n = grant;
    ready_n = wr_ready;
    addr_n  = wr_addr;
    data_n  = wr_data;
    done_n  = '0;
    busy_n  = mc_busy;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_n = pick;
          addr_n  = address[pick];
          data_n  = color[pick];
          ready_n = 1'b1;
          busy_n  = '1;
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (wr_done) begin
          ready_n = 1'b0;
          done_n  = NUM_WORKERS'(1) << grant;
          ptr_n   = (grant == IW'(NUM_WORKERS - 1)) ? '0
                                                   : grant + IW'(1);
          state_n = DONE;
        end
      end
      DONE: begin
        busy_n  = '0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      wr_ready <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      mc_done  <= '0;
      mc_busy  <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= ptr_n;
      grant    <= grant_n;
      wr_ready <= ready_n;
      wr_addr  <= addr_n;
      wr_data  <= data_n;
      mc_done  <= done_n;
      mc_busy  <= busy_n;
    end
  end

`ifdef MC_PIX_CNT_EN
  always_ff @(posedge clk) begin
    if (n_rst) begin
      pix_count <= '0;
    end else if (cnt_clr) begin
      pix_count <= '0;
    end else if (state == WRITE && wr_done) begin
      pix_count <= pix_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Scoreboard bench for pixel_write_arbiter with a worker and port model.
// Counter checks run when MC_PIX_CNT_EN is defined.
module tb_pixel_write_arbiter;

  localparam int NW = 16;

  logic                   clk;
  logic                   n_rst;
  logic [NW-1:0]          jw_done;
  logic [NW-1:0][31:0]    color;
  logic [NW-1:0][31:0]    address;
  logic                   wr_done;
  logic [NW-1:0]          mc_done;
  logic [NW-1:0]          mc_busy;
  logic [31:0]            wr_addr;
  logic [31:0]            wr_data;
  logic                   wr_ready;
`ifdef MC_PIX_CNT_EN
  logic                   cnt_clr;
  logic [31:0]            pix_count;
`endif

  pixel_write_arbiter #(
    .NUM_WORKERS (NW),
    .ADDR_W      (32),
    .DATA_W      (32)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .jw_done   (jw_done),
    .color     (color),
    .address   (address),
    .wr_done   (wr_done),
    .mc_done   (mc_done),
    .mc_busy   (mc_busy),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready)
`ifdef MC_PIX_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .pix_count (pix_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int exp_q[$];
  int wait_cfg = 0;
  int wcnt = 0;
  bit clr_on_done = 0;
  bit prev_ready = 0;
  logic [NW-1:0] prev_done = '0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_data = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000 + 32'(i) * 32'h10;
  endfunction

  function automatic logic [31:0] col_of(input int i);
    return 32'hFF00FF00 ^ (32'(i) * 32'h01010101);
  endfunction

  // one clock: sample after the edge, score, then update workers and port
  task automatic step();
    int idx;
    int e;
    @(posedge clk);
    #1;
    if (wr_ready && !prev_ready) begin
      cap_addr = wr_addr;
      cap_data = wr_data;
    end
    if (wr_ready) begin
      check("busy", mc_busy, {NW{1'b1}});
      if (prev_ready) begin
        check("hold_addr", wr_addr, cap_addr);
        check("hold_data", wr_data, cap_data);
      end
    end
    if (mc_done != '0) begin
      check("onehot", $countones(mc_done), 1);
      check("pulse", prev_done, '0);
      idx = 0;
      for (int i = 0; i < NW; i++) if (mc_done[i]) idx = i;
      if (exp_q.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("grant", idx, e);
        check("addr", cap_addr, addr_of(e));
        check("data", cap_data, col_of(e));
      end
      jw_done = jw_done & ~mc_done;
    end
    prev_ready = wr_ready;
    prev_done  = mc_done;
    wr_done = 1'b0;
`ifdef MC_PIX_CNT_EN
    cnt_clr = 1'b0;
`endif
    if (wr_ready) begin
      if (wcnt == wait_cfg) begin
        wr_done = 1'b1;
        wcnt = 0;
`ifdef MC_PIX_CNT_EN
        if (clr_on_done) cnt_clr = 1'b1;
`endif
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(jw_done == '0 && mc_busy == '0 && !wr_ready) && n < 500);
    if (n >= 500) check("timeout", 1, 0);
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    step();
    step();
    n_rst = 1'b0;
  endtask

  initial begin
    int cnt;
    n_rst   = 1'b1;
    jw_done = '0;
    wr_done = 1'b0;
`ifdef MC_PIX_CNT_EN
    cnt_clr = 1'b0;
`endif
    for (int i = 0; i < NW; i++) begin
      address[i] = addr_of(i);
      color[i]   = col_of(i);
    end

    do_reset();
    check("rst_ready", wr_ready, 0);
    check("rst_busy", mc_busy, 0);
    check("rst_done", mc_done, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);

    // single request, port waits two cycles
    wait_cfg = 2;
    exp_q.push_back(0);
    jw_done = 16'h0001;
    step();
    check("lat_ready", wr_ready, 1);
    check("lat_addr", wr_addr, 32'h1000);
    check("lat_data", wr_data, 32'hFF00FF00);
    drain();
    wait_cfg = 0;

    // rr_ptr is now 1
    exp_q.push_back(1);
    exp_q.push_back(0);
    jw_done = 16'h0003;
    drain();

    // all workers at once, zero-wait port
    do_reset();
    for (int i = 0; i < NW; i++) exp_q.push_back(i);
    jw_done = '1;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(jw_done == '0 && mc_busy == '0) && cnt < 200);
    check("cycles16", cnt, 48);

    // move rr_ptr to 5, then 15, 0, 4
    exp_q.push_back(4);
    jw_done = 16'h0010;
    drain();
    exp_q.push_back(15);
    exp_q.push_back(0);
    exp_q.push_back(4);
    jw_done = 16'h8011;
    drain();

    // spurious wr_done while idle
    step();
    wr_done = 1'b1;
    step();
    check("spur_done", mc_done, 0);
    check("spur_ready", wr_ready, 0);
    check("spur_busy", mc_busy, 0);
    step();
    check("spur_done2", mc_done, 0);

    // reset in the middle of a write to worker 3
    wait_cfg = 10;
    exp_q.push_back(3);
    jw_done = 16'h0008;
    step();
    check("mid_ready", wr_ready, 1);
    step();
    n_rst = 1'b1;
    step();
    n_rst = 1'b0;
    check("mr_ready", wr_ready, 0);
    check("mr_done", mc_done, 0);
    check("mr_busy", mc_busy, 0);
    check("mr_pend", jw_done, 16'h0008);
    wait_cfg = 0;
    step();
    check("mr_regrant", wr_ready, 1);
    check("mr_addr", wr_addr, addr_of(3));
    drain();

`ifdef MC_PIX_CNT_EN
    cnt_clr = 1'b1;
    step();
    check("cnt_clr0", pix_count, 0);
    for (int k = 0; k < 10; k++) exp_q.push_back((k + 4) % 10);
    jw_done = 16'h03FF;
    drain();
    check("cnt10", pix_count, 10);
    clr_on_done = 1;
    exp_q.push_back(10);
    jw_done = 16'h0400;
    drain();
    clr_on_done = 0;
    check("cnt_clr_wins", pix_count, 0);
`endif

    check("sb_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
